// File: rtl/cache_refill_ctrl.sv
// Direct-mapped cache refill controller: serves hits in one cycle and refills whole lines over a req/gnt + rvalid memory handshake.
// Optional hit/miss statistics counters are built when the CACHE_STATS_EN macro is defined.
module cache_refill_ctrl #(
   parameter int TAG_W  = 28,
   parameter int LINE_W = 2,
   parameter int WORD_W = 2,
   parameter int DATA_W = 32
`ifdef CACHE_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  hit,
   input  logic                                  miss,
   input  logic [TAG_W-1:0]                      tag_in,
   input  logic [LINE_W-1:0]                     lineid_in,
   input  logic [WORD_W-1:0]                     wordid_in,
   input  logic                                  flush,
   output logic [(1<<LINE_W)-1:0][TAG_W-1:0]     tag_ctrl,
   output logic [(1<<LINE_W)-1:0]                valid_ctrl,
   output logic [DATA_W-1:0]                     cpu_rdata,
   output logic                                  cpu_rvalid,
   output logic                                  cpu_stall,
   output logic                                  mem_req,
   output logic [31:0]                           mem_addr,
   input  logic                                  mem_gnt,
   input  logic                                  mem_rvalid,
   input  logic [DATA_W-1:0]                     mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [CNT_W-1:0]                      hit_count,
   output logic [CNT_W-1:0]                      miss_count
`endif
);

   localparam int LINES = 1 << LINE_W;
   localparam int WORDS = 1 << WORD_W;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, COMMIT, RESP} state_t;

   state_t              state;
   logic [TAG_W-1:0]    req_tag;
   logic [LINE_W-1:0]   req_line;
   logic [WORD_W-1:0]   req_word;
   logic [WORD_W-1:0]   word_ctr;
   logic [DATA_W-1:0]   data_mem [LINES][WORDS];

   assign cpu_stall = (state != IDLE);
   assign mem_req   = (state == REQ);
   assign mem_addr  = 32'({req_tag, req_line, word_ctr});

   // Control FSM; the line becomes valid only in COMMIT, after every word has landed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         valid_ctrl <= '0;
         tag_ctrl   <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         word_ctr   <= '0;
         req_tag    <= '0;
         req_line   <= '0;
         req_word   <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  valid_ctrl <= '0;
               end else if (miss) begin
                  req_tag  <= tag_in;
                  req_line <= lineid_in;
                  req_word <= wordid_in;
                  word_ctr <= '0;
                  state    <= REQ;
               end else if (hit) begin
                  cpu_rvalid <= 1'b1;
                  cpu_rdata  <= data_mem[lineid_in][wordid_in];
               end
            end
            REQ: begin
               if (mem_gnt) state <= WAIT;
            end
            WAIT: begin
               if (mem_rvalid) begin
                  if (word_ctr == WORD_W'(WORDS - 1)) begin
                     state <= COMMIT;
                  end else begin
                     word_ctr <= word_ctr + WORD_W'(1);
                     state    <= REQ;
                  end
               end
            end
            COMMIT: begin
               tag_ctrl[req_line]   <= req_tag;
               valid_ctrl[req_line] <= 1'b1;
               cpu_rvalid           <= 1'b1;
               cpu_rdata            <= data_mem[req_line][req_word];
               state                <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Data array carries no reset; writes are gated so a reset mid-refill cannot land a late word.
   always_ff @(posedge clk) begin
      if (!rst && state == WAIT && mem_rvalid) begin
         data_mem[req_line][word_ctr] <= mem_rdata;
      end
   end

`ifdef CACHE_STATS_EN
   // Saturating counters of hits served and misses accepted; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && !flush) begin
         if (miss) begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
         end else if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: scenario tasks plus randomized accesses against a line-level cache model.
// Builds the statistics scenario when CACHE_STATS_EN is defined.
module tb_cache_refill_ctrl;

   localparam int TAG_W  = 28;
   localparam int LINE_W = 2;
   localparam int WORD_W = 2;
   localparam int DATA_W = 32;
`ifdef CACHE_STATS_EN
   localparam int CNT_W  = 2;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      hit, miss, flush;
   logic [TAG_W-1:0]          tag_in;
   logic [LINE_W-1:0]         lineid_in;
   logic [WORD_W-1:0]         wordid_in;
   logic [3:0][TAG_W-1:0]     tag_ctrl;
   logic [3:0]                valid_ctrl;
   logic [DATA_W-1:0]         cpu_rdata;
   logic                      cpu_rvalid, cpu_stall;
   logic                      mem_req;
   logic [31:0]               mem_addr;
   logic                      mem_gnt;
   logic                      mem_rvalid;
   logic [DATA_W-1:0]         mem_rdata;
`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0]          hit_count, miss_count;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: what each line holds and what memory would return for any word address.
   bit                model_valid [4];
   logic [TAG_W-1:0]  model_tag   [4];
   logic [31:0]       model_data  [4][4];
   logic [31:0]       backing     [logic [31:0]];
   logic [31:0]       req_addrs   [$];
   bit                inject_rvalid = 1'b0;

   always #5 clk = ~clk;

   cache_refill_ctrl #(
      .TAG_W(TAG_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .DATA_W(DATA_W)
`ifdef CACHE_STATS_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .rst(rst), .hit(hit), .miss(miss),
      .tag_in(tag_in), .lineid_in(lineid_in), .wordid_in(wordid_in), .flush(flush),
      .tag_ctrl(tag_ctrl), .valid_ctrl(valid_ctrl),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   function automatic logic [31:0] make_addr(input logic [TAG_W-1:0] t, input logic [1:0] l, input logic [1:0] w);
      return {t, l, w};
   endfunction

   function automatic logic [31:0] mem_value(input logic [31:0] a);
      if (backing.exists(a)) return backing[a];
      return a ^ 32'h5A5A_F00D;
   endfunction

   function automatic logic [3:0] model_valid_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = model_valid[i];
      return v;
   endfunction

   // Memory responder: one word returned the cycle after each grant.
   initial begin
      logic        fire;
      logic [31:0] addr;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         fire = mem_req && mem_gnt;
         addr = mem_addr;
         @(posedge clk);
         #1;
         mem_rvalid = fire || inject_rvalid;
         mem_rdata  = fire ? mem_value(addr) : 32'hDEAD_BEEF;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         model_valid[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; hit = 1'b0; miss = 1'b0; flush = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model_tag[i] = '0;
      model_clear();
   endtask

   // Issue one lookup result; hit or miss is decided by the model. Returns what the DUT did.
   task automatic run_access(input logic [TAG_W-1:0] t, input logic [1:0] l, input logic [1:0] w,
                             output logic [31:0] rdata, output int lat, output int stall_cycles,
                             output bit stall_after, output bit timeout);
      bit is_hit;
      is_hit = model_valid[l] && (model_tag[l] == t);
      req_addrs.delete();
      if (!is_hit) begin
         for (int k = 0; k < 4; k++)
            if (!backing.exists(make_addr(t, l, 2'(k)))) backing[make_addr(t, l, 2'(k))] = $urandom;
      end
      tag_in = t; lineid_in = l; wordid_in = w;
      miss = !is_hit;
      hit  = is_hit ? 1'b1 : ($urandom_range(0, 1) == 1);
      tick();
      hit = 1'b0; miss = 1'b0;
      lat = 0; stall_cycles = 0; timeout = 1'b1; rdata = '0;
      for (int n = 1; n <= 100; n++) begin
         if (cpu_stall) stall_cycles++;
         if (mem_req && mem_gnt) req_addrs.push_back(mem_addr);
         if (cpu_rvalid) begin
            lat = n; rdata = cpu_rdata; timeout = 1'b0;
            break;
         end
         tick();
      end
      tick();
      stall_after = cpu_stall;
      if (!is_hit) begin
         model_valid[l] = 1'b1;
         model_tag[l]   = t;
         for (int k = 0; k < 4; k++) model_data[l][k] = mem_value(make_addr(t, l, 2'(k)));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; hit = 1'b0; miss = 1'b1; flush = 1'b0;
      tag_in = 28'h0FFFFFF; lineid_in = 2'd1; wordid_in = 2'd3; mem_gnt = 1'b1;
      tick(); tick();
      tests_run++; if (valid_ctrl !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0000", valid_ctrl); end
      tests_run++; if (tag_ctrl !== '0) begin tests_failed++; $display("[TB] FAIL reset_tag: got %h expected 0", tag_ctrl); end
      tests_run++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== '0) begin tests_failed++; $display("[TB] FAIL reset_cpu: got rvalid=%b rdata=%h expected 0/0", cpu_rvalid, cpu_rdata); end
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_idle: got req=%b stall=%b expected 0/0", mem_req, cpu_stall); end
      miss = 1'b0;
      do_reset();
      tick();
      tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_stall: got %b expected 0", cpu_stall); end
   endtask

   task automatic test_refill();
      logic [31:0] rd; int lat, sc; bit sa, to;
      for (int k = 0; k < 4; k++) backing[make_addr(28'h1234567, 2'd2, 2'(k))] = 32'hA0 + k;
      run_access(28'h1234567, 2'd2, 2'd1, rd, lat, sc, sa, to);
      tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL refill_timeout: got timeout expected rvalid"); end
      tests_run++; if (rd !== 32'hA1) begin tests_failed++; $display("[TB] FAIL refill_data: got %h expected a1", rd); end
      tests_run++; if (lat !== 10) begin tests_failed++; $display("[TB] FAIL refill_latency: got %0d expected 10", lat); end
      tests_run++; if (sc !== 10 || sa !== 1'b0) begin tests_failed++; $display("[TB] FAIL refill_stall: got %0d cycles after=%b expected 10/0", sc, sa); end
      tests_run++; if (req_addrs.size() !== 4) begin tests_failed++; $display("[TB] FAIL refill_req_count: got %0d expected 4", req_addrs.size()); end
      for (int k = 0; k < 4 && k < req_addrs.size(); k++) begin
         tests_run++; if (req_addrs[k] !== make_addr(28'h1234567, 2'd2, 2'(k))) begin tests_failed++; $display("[TB] FAIL refill_addr%0d: got %h expected %h", k, req_addrs[k], make_addr(28'h1234567, 2'd2, 2'(k))); end
      end
      tests_run++; if (valid_ctrl !== 4'b0100) begin tests_failed++; $display("[TB] FAIL refill_valid: got %b expected 0100", valid_ctrl); end
      tests_run++; if (tag_ctrl[2] !== 28'h1234567) begin tests_failed++; $display("[TB] FAIL refill_tag: got %h expected 1234567", tag_ctrl[2]); end
   endtask

   task automatic test_back_to_back();
      tag_in = 28'h1234567; lineid_in = 2'd2; wordid_in = 2'd0; hit = 1'b1;
      tick();
      tests_run++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA0) begin tests_failed++; $display("[TB] FAIL b2b_first: got rvalid=%b data=%h expected 1/a0", cpu_rvalid, cpu_rdata); end
      wordid_in = 2'd3;
      tick();
      tests_run++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA3) begin tests_failed++; $display("[TB] FAIL b2b_second: got rvalid=%b data=%h expected 1/a3", cpu_rvalid, cpu_rdata); end
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_req: got req=%b stall=%b expected 0/0", mem_req, cpu_stall); end
      hit = 1'b0;
      tick();
      tests_run++; if (cpu_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_strobe_end: got %b expected 0", cpu_rvalid); end
   endtask

   task automatic test_gnt_stall();
      logic [TAG_W-1:0] t;
      int lat;
      bit ok_hold;
      t = 28'h0ABCDEF;
      for (int k = 0; k < 4; k++) backing[make_addr(t, 2'd1, 2'(k))] = $urandom;
      mem_gnt = 1'b0;
      tag_in = t; lineid_in = 2'd1; wordid_in = 2'd2; miss = 1'b1;
      tick();
      miss = 1'b0;
      ok_hold = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         if (mem_req !== 1'b1 || mem_addr !== make_addr(t, 2'd1, 2'd0)) ok_hold = 1'b0;
         if (n < 6) tick();
      end
      tests_run++; if (ok_hold !== 1'b1) begin tests_failed++; $display("[TB] FAIL gnt_hold: got req=%b addr=%h expected 1/%h", mem_req, mem_addr, make_addr(t, 2'd1, 2'd0)); end
      mem_gnt = 1'b1;
      lat = 0;
      for (int n = 6; n <= 60; n++) begin
         if (cpu_rvalid) begin lat = n; break; end
         tick();
      end
      tests_run++; if (lat !== 15) begin tests_failed++; $display("[TB] FAIL gnt_latency: got %0d expected 15", lat); end
      tests_run++; if (cpu_rdata !== backing[make_addr(t, 2'd1, 2'd2)]) begin tests_failed++; $display("[TB] FAIL gnt_data: got %h expected %h", cpu_rdata, backing[make_addr(t, 2'd1, 2'd2)]); end
      tick();
      model_valid[1] = 1'b1; model_tag[1] = t;
      for (int k = 0; k < 4; k++) model_data[1][k] = backing[make_addr(t, 2'd1, 2'(k))];
      tests_run++; if (valid_ctrl !== model_valid_vec()) begin tests_failed++; $display("[TB] FAIL gnt_valid: got %b expected %b", valid_ctrl, model_valid_vec()); end
   endtask

   task automatic test_reset_mid_refill();
      logic [TAG_W-1:0] t;
      logic [31:0] rd; int lat, sc; bit sa, to, quiet;
      t = 28'($urandom);
      for (int k = 0; k < 4; k++) backing[make_addr(t, 2'd3, 2'(k))] = $urandom;
      mem_gnt = 1'b1;
      tag_in = t; lineid_in = 2'd3; wordid_in = 2'd1; miss = 1'b1;
      tick();
      miss = 1'b0;
      for (int n = 1; n < 5; n++) tick();
      tests_run++; if (mem_req !== 1'b1 || mem_addr !== make_addr(t, 2'd3, 2'd2)) begin tests_failed++; $display("[TB] FAIL mid_req_word2: got req=%b addr=%h expected 1/%h", mem_req, mem_addr, make_addr(t, 2'd3, 2'd2)); end
      tick();
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_wait: got req=%b stall=%b expected 0/1", mem_req, cpu_stall); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      tests_run++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || valid_ctrl !== 4'b0) begin tests_failed++; $display("[TB] FAIL mid_reset: got req=%b stall=%b valid=%b expected 0/0/0000", mem_req, cpu_stall, valid_ctrl); end
      inject_rvalid = 1'b1;
      quiet = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0 || valid_ctrl !== 4'b0) quiet = 1'b0;
      end
      inject_rvalid = 1'b0;
      tick(); tick();
      tests_run++; if (quiet !== 1'b1) begin tests_failed++; $display("[TB] FAIL late_rvalid: got activity expected idle"); end
      run_access(t, 2'd3, 2'd1, rd, lat, sc, sa, to);
      tests_run++; if (to !== 1'b0 || lat !== 10 || rd !== model_data[3][1]) begin tests_failed++; $display("[TB] FAIL post_reset_refill: got lat=%0d data=%h expected 10/%h", lat, rd, model_data[3][1]); end
   endtask

   task automatic test_flush_hit();
      logic [31:0] rd; int lat, sc; bit sa, to;
      run_access(28'h00000AA, 2'd2, 2'd3, rd, lat, sc, sa, to);
      flush = 1'b1; hit = 1'b1; tag_in = 28'h00000AA; lineid_in = 2'd2; wordid_in = 2'd3;
      tick();
      flush = 1'b0; hit = 1'b0;
      model_clear();
      tests_run++; if (cpu_rvalid !== 1'b0 || valid_ctrl !== 4'b0) begin tests_failed++; $display("[TB] FAIL flush_hit: got rvalid=%b valid=%b expected 0/0000", cpu_rvalid, valid_ctrl); end
      flush = 1'b1; miss = 1'b1;
      tick();
      flush = 1'b0; miss = 1'b0;
      tests_run++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_miss: got stall=%b req=%b expected 0/0", cpu_stall, mem_req); end
      run_access(28'h00000AA, 2'd2, 2'd3, rd, lat, sc, sa, to);
      tests_run++; if (to !== 1'b0 || lat !== 10 || req_addrs.size() !== 4 || rd !== model_data[2][3]) begin tests_failed++; $display("[TB] FAIL flush_refill: got lat=%0d reqs=%0d data=%h expected 10/4/%h", lat, req_addrs.size(), rd, model_data[2][3]); end
   endtask

   task automatic test_random();
      logic [TAG_W-1:0] pool [3];
      logic [TAG_W-1:0] t;
      logic [1:0] l, w;
      logic [31:0] rd; int lat, sc; bit sa, to, exp_hit, addr_ok;
      pool[0] = 28'h0000001; pool[1] = 28'hFFFFFFF; pool[2] = 28'h5555555;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1; hit = 1'($urandom); miss = 1'($urandom);
            tick();
            flush = 1'b0; hit = 1'b0; miss = 1'b0;
            model_clear();
            tests_run++; if (cpu_rvalid !== 1'b0 || cpu_stall !== 1'b0 || valid_ctrl !== 4'b0) begin tests_failed++; $display("[TB] FAIL rand_flush%0d: got rvalid=%b stall=%b valid=%b expected 0/0/0000", it, cpu_rvalid, cpu_stall, valid_ctrl); end
         end else begin
            t = pool[$urandom_range(0, 2)];
            l = 2'($urandom); w = 2'($urandom);
            exp_hit = model_valid[l] && (model_tag[l] == t);
            run_access(t, l, w, rd, lat, sc, sa, to);
            addr_ok = (req_addrs.size() == (exp_hit ? 0 : 4));
            for (int k = 0; k < req_addrs.size() && k < 4; k++)
               if (req_addrs[k] !== make_addr(t, l, 2'(k))) addr_ok = 1'b0;
            tests_run++; if (to !== 1'b0 || rd !== model_data[l][w]) begin tests_failed++; $display("[TB] FAIL rand_data%0d: got %h expected %h", it, rd, model_data[l][w]); end
            tests_run++; if (lat !== (exp_hit ? 1 : 10) || sc !== (exp_hit ? 0 : 10) || sa !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_timing%0d: got lat=%0d stall=%0d expected %0d/%0d", it, lat, sc, exp_hit ? 1 : 10, exp_hit ? 0 : 10); end
            tests_run++; if (addr_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_mem%0d: got %0d requests expected %0d", it, req_addrs.size(), exp_hit ? 0 : 4); end
            tests_run++; if (valid_ctrl !== model_valid_vec() || tag_ctrl[l] !== t) begin tests_failed++; $display("[TB] FAIL rand_tags%0d: got valid=%b tag=%h expected %b/%h", it, valid_ctrl, tag_ctrl[l], model_valid_vec(), t); end
         end
      end
   endtask

`ifdef CACHE_STATS_EN
   task automatic test_stats();
      logic [31:0] rd; int lat, sc; bit sa, to;
      int eh, em, maxc;
      logic [TAG_W-1:0] tg [6];
      logic [1:0]       ln [6];
      eh = 0; em = 0; maxc = (1 << CNT_W) - 1;
      do_reset();
      tests_run++; if (hit_count !== '0 || miss_count !== '0) begin tests_failed++; $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", hit_count, miss_count); end
      tg[0] = 28'h11; ln[0] = 2'd0; tg[1] = 28'h22; ln[1] = 2'd1;
      tg[2] = 28'h11; ln[2] = 2'd0; tg[3] = 28'h11; ln[3] = 2'd0; tg[4] = 28'h22; ln[4] = 2'd1;
      for (int i = 0; i < 5; i++) begin
         if (model_valid[ln[i]] && model_tag[ln[i]] == tg[i]) eh = (eh < maxc) ? eh + 1 : eh;
         else em = (em < maxc) ? em + 1 : em;
         run_access(tg[i], ln[i], 2'($urandom), rd, lat, sc, sa, to);
      end
      tests_run++; if (hit_count !== CNT_W'(3) || miss_count !== CNT_W'(2)) begin tests_failed++; $display("[TB] FAIL stats_counts: got %0d/%0d expected 3/2", hit_count, miss_count); end
      tg[0] = 28'h11; ln[0] = 2'd0; tg[1] = 28'h33; ln[1] = 2'd2; tg[2] = 28'h44; ln[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
         if (model_valid[ln[i]] && model_tag[ln[i]] == tg[i]) eh = (eh < maxc) ? eh + 1 : eh;
         else em = (em < maxc) ? em + 1 : em;
         run_access(tg[i], ln[i], 2'($urandom), rd, lat, sc, sa, to);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_clear();
      tests_run++; if (hit_count !== CNT_W'(eh) || miss_count !== CNT_W'(em)) begin tests_failed++; $display("[TB] FAIL stats_saturate: got %0d/%0d expected %0d/%0d", hit_count, miss_count, eh, em); end
   endtask
`endif

   initial begin
      rst = 1'b1; hit = 1'b0; miss = 1'b0; flush = 1'b0; mem_gnt = 1'b1;
      tag_in = '0; lineid_in = '0; wordid_in = '0;
      test_reset();
      test_refill();
      test_back_to_back();
      test_gnt_stall();
      test_reset_mid_refill();
      test_flush_hit();
      test_random();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
